// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, FSM state type and helpers for the N-way cache array
//
// Contents:
//   DEF_*          default geometry used as parameter defaults by cache_nway_array
//   DEF_LINE_WIDTH default line width (words per line * bits per word)
//   MAX_WAYS       widest one-hot vector accepted by onehot_to_index
//   cache_state_e  flush sequencer state (IDLE, FLUSH)
//   onehot_to_index  index of the set bit in a one-hot vector (0 when empty)
package cache_pkg;

    localparam int DEF_WAY_NUM        = 4;
    localparam int DEF_WAY_BIT        = 2;
    localparam int DEF_SET_ADDR_WIDTH = 5;
    localparam int DEF_TAG_BITS       = 23;
    localparam int DEF_WORD_NUM       = 4;
    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_BYTE_NUM       = 4;
    localparam int DEF_LINE_WIDTH     = DEF_WORD_NUM * DEF_WORD_WIDTH;
    localparam int MAX_WAYS           = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cache_state_e;

    function automatic int onehot_to_index(input logic [MAX_WAYS-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// rtl/cache_plru_tree.sv - combinational tree pseudo-LRU update and victim select for one set
//
// Ports:
//   bits_in     current tree bits of the set; bit k-1 holds heap node k (node 1 is the root)
//   access_way  way being touched this cycle
//   bits_out    tree bits after marking access_way most recent
//   victim_way  way the current bits point at
// A node bit of 1 steers toward the right (higher-index) child.
module cache_plru_tree #(
    parameter int WAY_NUM = 4,
    parameter int WAY_BIT = 2
) (
    input  logic [WAY_NUM-2:0] bits_in,
    input  logic [WAY_BIT-1:0] access_way,
    output logic [WAY_NUM-2:0] bits_out,
    output logic [WAY_BIT-1:0] victim_way
);

    logic [WAY_BIT-1:0] node;
    logic [WAY_BIT:0]   leaf;

    // Walk root to leaf; the final shift drops the implicit leaf-level MSB,
    // leaving exactly the way index.
    always_comb begin
        node = WAY_BIT'(1);
        for (int l = 0; l < WAY_BIT; l++) begin
            node = (node << 1) | WAY_BIT'(bits_in[node - WAY_BIT'(1)]);
        end
        victim_way = node;
    end

    // Heap index of the leaf for access_way is WAY_NUM + access_way.
    assign leaf = {1'b1, access_way};

    // Each ancestor points away from the child on the accessed path.
    always_comb begin
        bits_out = bits_in;
        for (int l = 0; l < WAY_BIT; l++) begin
            bits_out[WAY_BIT'(leaf >> (l + 1)) - WAY_BIT'(1)] = ~leaf[l];
        end
    end

endmodule

// File: rtl/cache_nway_array.sv
// rtl/cache_nway_array.sv - N-way set-associative tag/data array with replacement state and flush
//
// Build option: CACHE_PLRU_EN selects per-set tree pseudo-LRU; otherwise one
// global round-robin pointer is used for replacement.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_wr, req_refill            store into hit way / install into victim way (refill wins)
//   req_addr, req_tag             set index and tag
//   req_word_en, req_byte_en      store enables (bytes within each enabled word)
//   req_wdata                     store or refill line data
//   resp_valid, resp_hit          registered result of an accepted request
//   resp_way                      one-hot hit way, or victim way on refill
//   resp_rdata                    hit line before the store, zero on miss
//   victim_valid/dirty/tag/data   old contents of the way replaced by a refill
//   flush_start, flush_busy       whole-cache invalidation request / in progress
module cache_nway_array
    import cache_pkg::*;
#(
    parameter int WAY_NUM        = DEF_WAY_NUM,
    parameter int WAY_BIT        = DEF_WAY_BIT,
    parameter int SET_ADDR_WIDTH = DEF_SET_ADDR_WIDTH,
    parameter int TAG_BITS       = DEF_TAG_BITS,
    parameter int WORD_NUM       = DEF_WORD_NUM,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int BYTE_NUM       = DEF_BYTE_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic                           req_refill,
    input  logic [SET_ADDR_WIDTH-1:0]      req_addr,
    input  logic [TAG_BITS-1:0]            req_tag,
    input  logic [WORD_NUM-1:0]            req_word_en,
    input  logic [BYTE_NUM-1:0]            req_byte_en,
    input  logic [WORD_NUM*WORD_WIDTH-1:0] req_wdata,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic [WAY_NUM-1:0]             resp_way,
    output logic [WORD_NUM*WORD_WIDTH-1:0] resp_rdata,
    output logic                           victim_valid,
    output logic                           victim_dirty,
    output logic [TAG_BITS-1:0]            victim_tag,
    output logic [WORD_NUM*WORD_WIDTH-1:0] victim_data,
    input  logic                           flush_start,
    output logic                           flush_busy
);

    localparam int SET_NUM    = 1 << SET_ADDR_WIDTH;
    localparam int LINE_WIDTH = WORD_NUM * WORD_WIDTH;
    localparam int BYTE_WIDTH = WORD_WIDTH / BYTE_NUM;

    cache_state_e              state;
    logic [SET_ADDR_WIDTH-1:0] flush_idx;

    logic [WAY_NUM-1:0]    valid_q [SET_NUM];
    logic [WAY_NUM-1:0]    dirty_q [SET_NUM];
    logic [TAG_BITS-1:0]   tag_q   [SET_NUM][WAY_NUM];
    logic [LINE_WIDTH-1:0] data_q  [SET_NUM][WAY_NUM];

    logic                  accept;
    logic [WAY_NUM-1:0]    hit_oh;
    logic                  hit;
    logic [WAY_BIT-1:0]    hit_idx;
    logic [LINE_WIDTH-1:0] hit_line;
    logic                  inv_found;
    logic [WAY_BIT-1:0]    inv_idx;
    logic [WAY_BIT-1:0]    repl_idx;
    logic [WAY_BIT-1:0]    victim_idx;
    logic [WAY_BIT-1:0]    access_idx;
    logic [WAY_NUM-1:0]    victim_oh;
    logic [LINE_WIDTH-1:0] store_line;

    // Flush owns the array for its whole duration, including the start cycle.
    assign req_ready = ~rst & (state == ST_IDLE) & ~flush_start;
    assign accept    = req_valid & req_ready;

    always_comb begin
        hit_oh    = '0;
        hit_line  = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (valid_q[req_addr][w] && (tag_q[req_addr][w] == req_tag)) begin
                hit_oh[w] = 1'b1;
                hit_line  = hit_line | data_q[req_addr][w];
            end
        end
        // Descending scan so the lowest invalid way is the one left standing.
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (!valid_q[req_addr][w]) begin
                inv_found = 1'b1;
                inv_idx   = WAY_BIT'(w);
            end
        end
    end

    assign hit        = |hit_oh;
    assign hit_idx    = WAY_BIT'(onehot_to_index(MAX_WAYS'(hit_oh)));
    assign victim_idx = inv_found ? inv_idx : repl_idx;
    assign access_idx = req_refill ? victim_idx : hit_idx;
    assign victim_oh  = {{(WAY_NUM-1){1'b0}}, 1'b1} << victim_idx;

    always_comb begin
        store_line = data_q[req_addr][hit_idx];
        for (int i = 0; i < WORD_NUM; i++) begin
            for (int j = 0; j < BYTE_NUM; j++) begin
                if (req_word_en[i] && req_byte_en[j]) begin
                    store_line[i*WORD_WIDTH + j*BYTE_WIDTH +: BYTE_WIDTH] =
                        req_wdata[i*WORD_WIDTH + j*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

`ifdef CACHE_PLRU_EN
    logic [WAY_NUM-2:0] plru_q [SET_NUM];
    logic [WAY_NUM-2:0] plru_next;

    cache_plru_tree #(
        .WAY_NUM (WAY_NUM),
        .WAY_BIT (WAY_BIT)
    ) u_plru (
        .bits_in    (plru_q[req_addr]),
        .access_way (access_idx),
        .bits_out   (plru_next),
        .victim_way (repl_idx)
    );
`else
    logic [WAY_BIT-1:0] rr_ptr;

    assign repl_idx = rr_ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            flush_idx    <= '0;
            flush_busy   <= 1'b0;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_way     <= '0;
            resp_rdata   <= '0;
            victim_valid <= 1'b0;
            victim_dirty <= 1'b0;
            victim_tag   <= '0;
            victim_data  <= '0;
            for (int s = 0; s < SET_NUM; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef CACHE_PLRU_EN
                plru_q[s]  <= '0;
`endif
            end
`ifndef CACHE_PLRU_EN
            rr_ptr <= '0;
`endif
        end else begin
            resp_valid <= accept;

            case (state)
                ST_IDLE: begin
                    if (flush_start) begin
                        state      <= ST_FLUSH;
                        flush_idx  <= '0;
                        flush_busy <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    valid_q[flush_idx] <= '0;
                    dirty_q[flush_idx] <= '0;
`ifdef CACHE_PLRU_EN
                    plru_q[flush_idx]  <= '0;
`endif
                    if (flush_idx == {SET_ADDR_WIDTH{1'b1}}) begin
                        state      <= ST_IDLE;
                        flush_busy <= 1'b0;
                    end else begin
                        flush_idx <= flush_idx + SET_ADDR_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                resp_hit   <= hit;
                resp_way   <= req_refill ? victim_oh : hit_oh;
                resp_rdata <= hit_line;
                if (req_refill) begin
                    victim_valid                  <= valid_q[req_addr][victim_idx];
                    victim_dirty                  <= dirty_q[req_addr][victim_idx];
                    victim_tag                    <= tag_q[req_addr][victim_idx];
                    victim_data                   <= data_q[req_addr][victim_idx];
                    valid_q[req_addr][victim_idx] <= 1'b1;
                    dirty_q[req_addr][victim_idx] <= 1'b0;
                end else if (req_wr && hit) begin
                    dirty_q[req_addr][hit_idx] <= 1'b1;
                end
`ifdef CACHE_PLRU_EN
                if (req_refill || hit) begin
                    plru_q[req_addr] <= plru_next;
                end
`else
                // Filling an empty way does not consume a round-robin turn.
                if (req_refill && !inv_found) begin
                    rr_ptr <= rr_ptr + WAY_BIT'(1);
                end
`endif
            end
        end
    end

    // Tag and line storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_refill) begin
                tag_q[req_addr][victim_idx]  <= req_tag;
                data_q[req_addr][victim_idx] <= req_wdata;
            end else if (req_wr && hit) begin
                data_q[req_addr][hit_idx] <= store_line;
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_array.sv
// tb/tb_cache_nway_array.sv - self-checking bench for cache_nway_array
module tb_cache_nway_array;

    localparam int WN   = 4;
    localparam int WB   = 2;
    localparam int SAW  = 5;
    localparam int TB   = 23;
    localparam int WDN  = 4;
    localparam int WW   = 32;
    localparam int BN   = 4;
    localparam int LW   = WDN * WW;
    localparam int SETS = 1 << SAW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_wr = 1'b0;
    logic            req_refill = 1'b0;
    logic [SAW-1:0]  req_addr = '0;
    logic [TB-1:0]   req_tag = '0;
    logic [WDN-1:0]  req_word_en = '0;
    logic [BN-1:0]   req_byte_en = '0;
    logic [LW-1:0]   req_wdata = '0;
    logic            resp_valid;
    logic            resp_hit;
    logic [WN-1:0]   resp_way;
    logic [LW-1:0]   resp_rdata;
    logic            victim_valid;
    logic            victim_dirty;
    logic [TB-1:0]   victim_tag;
    logic [LW-1:0]   victim_data;
    logic            flush_start = 1'b0;
    logic            flush_busy;

    always #5 clk = ~clk;

    cache_nway_array #(
        .WAY_NUM(WN), .WAY_BIT(WB), .SET_ADDR_WIDTH(SAW), .TAG_BITS(TB),
        .WORD_NUM(WDN), .WORD_WIDTH(WW), .BYTE_NUM(BN)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_refill(req_refill),
        .req_addr(req_addr), .req_tag(req_tag), .req_word_en(req_word_en),
        .req_byte_en(req_byte_en), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_rdata(resp_rdata),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .victim_data(victim_data), .flush_start(flush_start), .flush_busy(flush_busy)
    );

    typedef struct {
        bit            refill;
        bit            hit;
        logic [WN-1:0] way;
        logic [LW-1:0] rdata;
        bit            vvalid;
        bit            vdirty;
        logic [TB-1:0] vtag;
        logic [LW-1:0] vdata;
    } exp_t;

    typedef struct {
        int            op;    // 0 lookup, 1 store, 2 refill
        int            s;
        logic [TB-1:0] t;
        logic [3:0]    wen;
        logic [3:0]    ben;
        logic [LW-1:0] wd;
        bit            eh;
        logic [WN-1:0] ew;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    bit            mvalid [SETS][WN];
    bit            mdirty [SETS][WN];
    logic [TB-1:0] mtag   [SETS][WN];
    logic [LW-1:0] mdata  [SETS][WN];
    bit   [2:0]    mplru  [SETS];
    int            mrr;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WN; w++) begin
                mvalid[s][w] = 1'b0;
                mdirty[s][w] = 1'b0;
            end
            mplru[s] = 3'b000;
        end
        mrr = 0;
    endfunction

    function automatic int model_repl(input int s);
`ifdef CACHE_PLRU_EN
        if (!mplru[s][0]) return mplru[s][1] ? 1 : 0;
        return mplru[s][2] ? 3 : 2;
`else
        return (s >= 0) ? mrr : mrr;
`endif
    endfunction

    function automatic void model_touch(input int s, input int w);
        // Root bit 1 means "right half is older"; leaf-pair bit 1 means "odd way is older".
        mplru[s][0] = (w < 2);
        if (w < 2) mplru[s][1] = (w == 0);
        else       mplru[s][2] = (w == 2);
    endfunction

    function automatic exp_t model_req(input int op, input int s, input logic [TB-1:0] t,
                                       input logic [3:0] wen, input logic [3:0] ben,
                                       input logic [LW-1:0] wd);
        exp_t e;
        int   h;
        int   v;
        h = -1;
        v = -1;
        e = '{default: 0};
        for (int w = 0; w < WN; w++) if (mvalid[s][w] && mtag[s][w] == t) h = w;
        e.hit    = (h >= 0);
        e.rdata  = (h >= 0) ? mdata[s][h] : '0;
        e.refill = (op == 2);
        if (op == 2) begin
            for (int w = WN - 1; w >= 0; w--) if (!mvalid[s][w]) v = w;
            if (v < 0) begin
                v   = model_repl(s);
                mrr = (mrr + 1) % WN;
            end
            e.vvalid    = mvalid[s][v];
            e.vdirty    = mdirty[s][v];
            e.vtag      = mtag[s][v];
            e.vdata     = mdata[s][v];
            e.way       = 4'b0001 << v;
            mvalid[s][v] = 1'b1;
            mdirty[s][v] = 1'b0;
            mtag[s][v]   = t;
            mdata[s][v]  = wd;
            model_touch(s, v);
        end else if (h >= 0) begin
            e.way = 4'b0001 << h;
            if (op == 1) begin
                for (int i = 0; i < WDN; i++)
                    for (int j = 0; j < BN; j++)
                        if (wen[i] && ben[j]) mdata[s][h][i*WW + j*8 +: 8] = wd[i*WW + j*8 +: 8];
                mdirty[s][h] = 1'b1;
            end
            model_touch(s, h);
        end
        return e;
    endfunction

    // Called just after a rising edge; leaves the time just after the next one.
    task automatic issue(input int op, input int s, input logic [TB-1:0] t, input logic [3:0] wen,
                         input logic [3:0] ben, input logic [LW-1:0] wd,
                         input bit use_c, input bit c_hit, input logic [WN-1:0] c_way);
        exp_t e;
        req_valid   = 1'b1;
        req_wr      = (op == 1);
        req_refill  = (op == 2);
        req_addr    = SAW'(s);
        req_tag     = t;
        req_word_en = wen;
        req_byte_en = ben;
        req_wdata   = wd;
        #1;
        check("req_ready", LW'(req_ready), LW'(1));
        e = model_req(op, s, t, wen, ben, wd);
        if (use_c) begin
            e.hit = c_hit;
            e.way = c_way;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_refill = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", LW'(1), LW'(0));
            end else begin
                mon_e = sb.pop_front();
                check("resp_hit", LW'(resp_hit), LW'(mon_e.hit));
                check("resp_way", LW'(resp_way), LW'(mon_e.way));
                check("resp_rdata", resp_rdata, mon_e.rdata);
                if (mon_e.refill) begin
                    check("victim_valid", LW'(victim_valid), LW'(mon_e.vvalid));
                    check("victim_dirty", LW'(victim_dirty), LW'(mon_e.vdirty));
                    check("victim_tag", LW'(victim_tag), LW'(mon_e.vtag));
                    check("victim_data", victim_data, mon_e.vdata);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, LW'(resp_valid), LW'(0));
        check({tag, "_resp_hit"}, LW'(resp_hit), LW'(0));
        check({tag, "_resp_way"}, LW'(resp_way), LW'(0));
        check({tag, "_resp_rdata"}, resp_rdata, LW'(0));
        check({tag, "_victim_valid"}, LW'(victim_valid), LW'(0));
        check({tag, "_victim_dirty"}, LW'(victim_dirty), LW'(0));
        check({tag, "_victim_tag"}, LW'(victim_tag), LW'(0));
        check({tag, "_victim_data"}, victim_data, LW'(0));
        check({tag, "_flush_busy"}, LW'(flush_busy), LW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t          tbl[11];
    logic [LW-1:0] zero;
    logic [LW-1:0] stored_line;
    int            rr_exp[5];
    bit            use_rr;
    int            cnt;
    int            ready_bad;

    initial begin
        zero        = '0;
        stored_line = fill(8'hA5);
        stored_line[39:32] = 8'hFF;
        rr_exp = '{0, 1, 2, 3, 0};
`ifdef CACHE_PLRU_EN
        use_rr = 1'b0;
`else
        use_rr = 1'b1;
`endif
        tbl[0]  = '{0, 3, 23'h12, 4'h0, 4'h0, zero,         1'b0, 4'b0000};
        tbl[1]  = '{2, 3, 23'h12, 4'h0, 4'h0, fill(8'hA5),  1'b0, 4'b0001};
        tbl[2]  = '{0, 3, 23'h12, 4'h0, 4'h0, zero,         1'b1, 4'b0001};
        tbl[3]  = '{1, 3, 23'h12, 4'h2, 4'h1, fill(8'hFF),  1'b1, 4'b0001};
        tbl[4]  = '{0, 3, 23'h12, 4'h0, 4'h0, zero,         1'b1, 4'b0001};
        tbl[5]  = '{2, 3, 23'h20, 4'h0, 4'h0, fill(8'hD1),  1'b0, 4'b0010};
        tbl[6]  = '{2, 3, 23'h21, 4'h0, 4'h0, fill(8'hD2),  1'b0, 4'b0100};
        tbl[7]  = '{2, 3, 23'h22, 4'h0, 4'h0, fill(8'hD3),  1'b0, 4'b1000};
        tbl[8]  = '{2, 3, 23'h23, 4'h0, 4'h0, fill(8'hD4),  1'b0, 4'b0001};
        tbl[9]  = '{0, 3, 23'h12, 4'h0, 4'h0, zero,         1'b0, 4'b0000};
        tbl[10] = '{0, 3, 23'h23, 4'h0, 4'h0, zero,         1'b1, 4'b0001};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        check("por_req_ready_in_reset", LW'(req_ready), LW'(0));
        rst = 1'b0;
        #1;
        check("por_req_ready", LW'(req_ready), LW'(1));
        @(posedge clk);
        #1;

        // Set 3: miss, refill, hit, partial store, eviction of the dirty line.
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].op, tbl[i].s, tbl[i].t, tbl[i].wen, tbl[i].ben, tbl[i].wd,
                  1'b1, tbl[i].eh, tbl[i].ew);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_table", LW'(sb.size()), LW'(0));
        check("evict_dirty", LW'(victim_dirty), LW'(1));
        check("evict_tag", LW'(victim_tag), LW'(23'h12));
        check("evict_data", victim_data, stored_line);

        // Fresh reset so the round-robin pointer starts at way 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            issue(2, 7, TB'(32'h40 + i), 4'h0, 4'h0, fill(8'(8'h40 + i)), 1'b1, 1'b0, 4'b0001 << i);
        for (int i = 0; i < 3; i++)
            issue(0, 7, TB'(32'h40 + i), 4'h0, 4'h0, zero, 1'b1, 1'b1, 4'b0001 << i);
        for (int i = 0; i < 5; i++)
            issue(2, 7, TB'(32'h50 + i), 4'h0, 4'h0, fill(8'(8'h50 + i)),
                  use_rr, 1'b0, 4'b0001 << rr_exp[i]);
        repeat (2) @(posedge clk);
        #1;
        check("drain_rr", LW'(sb.size()), LW'(0));

        // Flush collides with a request: flush wins.
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 5'd7;
        req_tag     = 23'h54;
        #1;
        check("flush_vs_req_ready", LW'(req_ready), LW'(0));
        @(posedge clk);
        #1;
        flush_start = 1'b0;
        req_valid   = 1'b0;
        model_reset();
        cnt       = 0;
        ready_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!flush_busy) break;
            cnt++;
            if (req_ready) ready_bad++;
        end
        check("flush_busy_cycles", LW'(cnt), LW'(32));
        check("ready_during_flush", LW'(ready_bad), LW'(0));
        @(posedge clk);
        #1;
        issue(0, 7, 23'h54, 4'h0, 4'h0, zero, 1'b1, 1'b0, 4'b0000);
        issue(0, 7, 23'h42, 4'h0, 4'h0, zero, 1'b1, 1'b0, 4'b0000);
        issue(0, 3, 23'h23, 4'h0, 4'h0, zero, 1'b1, 1'b0, 4'b0000);

        // Reset in the middle of a flush, with a line still ahead of the sequencer.
        issue(2, 5, 23'h60, 4'h0, 4'h0, fill(8'h60), 1'b1, 1'b0, 4'b0001);
        issue(2, 12, 23'h61, 4'h0, 4'h0, fill(8'h61), 1'b1, 1'b0, 4'b0001);
        repeat (2) @(posedge clk);
        #1;
        flush_start = 1'b1;
        @(posedge clk);
        #1;
        flush_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_abort", LW'(flush_busy), LW'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort_req_ready_in_reset", LW'(req_ready), LW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_req_ready", LW'(req_ready), LW'(1));
        check("abort_flush_busy", LW'(flush_busy), LW'(0));
        @(posedge clk);
        #1;
        issue(0, 12, 23'h61, 4'h0, 4'h0, zero, 1'b1, 1'b0, 4'b0000);
        issue(0, 5, 23'h60, 4'h0, 4'h0, zero, 1'b1, 1'b0, 4'b0000);
        issue(2, 12, 23'h62, 4'h0, 4'h0, fill(8'h62), 1'b1, 1'b0, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        check("drain_final", LW'(sb.size()), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
